// File: rtl/key_load_ctrl_if.sv
// Load handshake between the key capture stage and the downstream register.
// Master offers load_data/load_valid; slave answers with load_ready.
interface key_load_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/key_load_ctrl.sv
// Pushbutton sync/debounce and switch capture, offering each captured
// word downstream over a valid/ready handshake on the system Clock.
module key_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 16,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              KEY,
    input  logic [DATA_W-1:0] SW,
    key_load_ctrl_if.master   ld,
    output logic              pressed,
    output logic [7:0]        press_count,
    output logic              overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state;
    logic [1:0]        key_q;
    logic [DATA_W-1:0] sw_q1;
    logic [DATA_W-1:0] sw_q2;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              key_s;
    logic              settled;
    logic              press_ev;

    // Sync flops reset to the released button level so no spurious press.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            key_q <= {2{KEY_ACTIVE_LOW}};
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            key_q <= {key_q[0], KEY};
            sw_q1 <= SW;
            sw_q2 <= sw_q1;
        end
    end

    assign key_s    = key_q[1] ^ KEY_ACTIVE_LOW;
    assign settled  = (cnt == LAST);
    assign press_ev = (state == PRESS_WAIT) && key_s && settled;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pressed     <= 1'b0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            press_count <= 8'd0;
            overrun     <= 1'b0;
        end else begin
            // Counter restarts on any agreeing sample and on acceptance.
            if ((key_s != pressed) && !settled)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            unique case (state)
                IDLE: begin
                    if (key_s) state <= PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (settled) begin
                        state   <= PRESSED;
                        pressed <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (!key_s) state <= RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (key_s) begin
                        state <= PRESSED;
                    end else if (settled) begin
                        state   <= IDLE;
                        pressed <= 1'b0;
                    end
                end
            endcase

            if (press_ev) begin
                press_count <= press_count + 8'd1;
                if (!valid_r || ld.load_ready) begin
                    data_r  <= sw_q2;
                    valid_r <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_r && ld.load_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign ld.load_data  = data_r;
    assign ld.load_valid = valid_r;

endmodule
